// File: rtl/p_det_scheduler.sv
// p_det_scheduler: sequences the representation selector p_det for the parameter extractor.
// A buffered random candidate, already legality-checked, is swapped in at round boundaries
// on a switch_req/switch_ack handshake. The scheduler stalls when a refresh is due and no
// candidate is buffered. p_det_prev keeps the selector in force before the last refresh,
// so the datapath can chain the old L_inv with the new L.
// Optional build macro RNG_HEALTH_EN: counts consecutive rejected RNG candidates and raises
// a sticky alarm after MAX_REJECT of them. Without it, alarm is tied low.
module p_det_scheduler #(
  parameter int unsigned REFRESH_PERIOD = 1,
  parameter int unsigned MAX_REJECT     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rnd,
  input  logic       rnd_valid,
  output logic       rnd_ready,
  input  logic       start,
  input  logic       switch_req,
  output logic       switch_ack,
  output logic [4:0] p_det,
  output logic [4:0] p_det_prev,
  output logic       next_ready,
  output logic       alarm
);

  // Width of the period counter; at least one bit, even for REFRESH_PERIOD == 1.
  localparam int unsigned     CntW    = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_PERIOD - 1);

  // Both parameters must be at least 1.
  if (REFRESH_PERIOD < 1 || MAX_REJECT < 1) begin : g_param_check
    $error("p_det_scheduler: REFRESH_PERIOD and MAX_REJECT must be >= 1");
  end

  typedef enum logic [0:0] {StRun, StStall} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [4:0]      nxt;
  logic            nxt_valid;

  logic            cand_fire;
  logic            cand_legal;
  logic            cand_accept;
  logic            cand_reject;

  // Prefetch buffer status; a new candidate is only taken while the buffer is empty.
  assign rnd_ready  = !nxt_valid;
  assign next_ready = nxt_valid;

  // Classify the candidate offered this cycle. 0 and 31 have no extractor entry, and
  // repeating the current selector would make the refresh a no-op.
  always_comb begin
    cand_fire   = rnd_valid && rnd_ready;
    cand_legal  = (rnd != 5'd0) && (rnd != 5'd31) && (rnd != p_det);
    cand_accept = cand_fire && cand_legal;
    cand_reject = cand_fire && !cand_legal;
  end

  // Scheduler FSM with registered selectors, ack pulse and prefetch buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StRun;
      cnt        <= CntLast;
      nxt        <= 5'd1;
      nxt_valid  <= 1'b0;
      p_det      <= 5'd1;
      p_det_prev <= 5'd1;
      switch_ack <= 1'b0;
    end else begin
      switch_ack <= 1'b0;

      // Candidate capture. It never coincides with a swap because rnd_ready is low
      // whenever a candidate is buffered, so the swap below may safely override nxt_valid.
      if (cand_accept) begin
        nxt       <= rnd;
        nxt_valid <= 1'b1;
      end

      unique case (state)
        StRun: begin
          // The request is ignored during the ack cycle, so one request is counted once.
          // start takes effect before a same-cycle request, which therefore refreshes.
          if (switch_req && !switch_ack) begin
            if (!start && (cnt != CntLast)) begin
              cnt        <= cnt + CntW'(1);
              switch_ack <= 1'b1;
            end else if (nxt_valid) begin
              p_det_prev <= p_det;
              p_det      <= nxt;
              nxt_valid  <= 1'b0;
              cnt        <= '0;
              switch_ack <= 1'b1;
            end else begin
              cnt   <= CntLast;
              state <= StStall;
            end
          end else if (start) begin
            cnt <= CntLast;
          end
        end
        StStall: begin
          // A refresh is owed. The candidate must first land in the buffer; there is no
          // bypass from rnd straight to p_det.
          if (nxt_valid) begin
            p_det_prev <= p_det;
            p_det      <= nxt;
            nxt_valid  <= 1'b0;
            cnt        <= '0;
            switch_ack <= 1'b1;
            state      <= StRun;
          end
        end
        default: state <= StRun;
      endcase
    end
  end

`ifdef RNG_HEALTH_EN
  localparam int unsigned     RejW   = $clog2(MAX_REJECT + 1);
  localparam logic [RejW-1:0] RejMax = RejW'(MAX_REJECT);

  logic [RejW-1:0] rej_cnt;

  // Consecutive-rejection counter (saturating) with a sticky alarm; only rst clears alarm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rej_cnt <= '0;
      alarm   <= 1'b0;
    end else if (cand_accept) begin
      rej_cnt <= '0;
    end else if (cand_reject) begin
      if (rej_cnt != RejMax) begin
        rej_cnt <= rej_cnt + RejW'(1);
      end
      if (rej_cnt == RejMax - RejW'(1)) begin
        alarm <= 1'b1;
      end
    end
  end
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_p_det_scheduler.sv
// Directed bench for p_det_scheduler: one instance with REFRESH_PERIOD=1 and one with
// REFRESH_PERIOD=3, both with MAX_REJECT=4.
module tb_p_det_scheduler;

`ifdef RNG_HEALTH_EN
  localparam bit HealthEn = 1'b1;
`else
  localparam bit HealthEn = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [4:0] rnd;
  logic       rnd_valid;
  logic       rnd_ready;
  logic       start;
  logic       switch_req;
  logic       switch_ack;
  logic [4:0] p_det;
  logic [4:0] p_det_prev;
  logic       next_ready;
  logic       alarm;

  logic [4:0] rnd3;
  logic       rnd_valid3;
  logic       rnd_ready3;
  logic       start3;
  logic       switch_req3;
  logic       switch_ack3;
  logic [4:0] p_det3;
  logic [4:0] p_det_prev3;
  logic       next_ready3;
  logic       alarm3;

  int errors = 0;
  int checks = 0;
  int ack_seen;

  p_det_scheduler #(.REFRESH_PERIOD(1), .MAX_REJECT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rnd        (rnd),
    .rnd_valid  (rnd_valid),
    .rnd_ready  (rnd_ready),
    .start      (start),
    .switch_req (switch_req),
    .switch_ack (switch_ack),
    .p_det      (p_det),
    .p_det_prev (p_det_prev),
    .next_ready (next_ready),
    .alarm      (alarm)
  );

  p_det_scheduler #(.REFRESH_PERIOD(3), .MAX_REJECT(4)) dut3 (
    .clk        (clk),
    .rst        (rst),
    .rnd        (rnd3),
    .rnd_valid  (rnd_valid3),
    .rnd_ready  (rnd_ready3),
    .start      (start3),
    .switch_req (switch_req3),
    .switch_ack (switch_ack3),
    .p_det      (p_det3),
    .p_det_prev (p_det_prev3),
    .next_ready (next_ready3),
    .alarm      (alarm3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs and inputs are handled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one candidate to the period-3 instance and expect it to be buffered.
  task automatic offer3(input logic [4:0] v, input string tag);
    rnd3       = v;
    rnd_valid3 = 1'b1;
    tick();
    rnd_valid3 = 1'b0;
    check(tag, next_ready3, 1);
  endtask

  // One request on the period-3 instance; req is still high during the ack cycle.
  task automatic req3(input logic [4:0] exp_p, input logic [4:0] exp_prev, input string tag);
    switch_req3 = 1'b1;
    tick();
    check({tag, "_ack"}, switch_ack3, 1);
    check({tag, "_p"}, p_det3, exp_p);
    check({tag, "_prev"}, p_det_prev3, exp_prev);
    tick();
    check({tag, "_ack_low"}, switch_ack3, 0);
    switch_req3 = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    rnd = '0; rnd_valid = 1'b0; start = 1'b0; switch_req = 1'b0;
    rnd3 = '0; rnd_valid3 = 1'b0; start3 = 1'b0; switch_req3 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_p_det", p_det, 1);
    check("rst_p_prev", p_det_prev, 1);
    check("rst_ack", switch_ack, 0);
    check("rst_next_ready", next_ready, 0);
    check("rst_rnd_ready", rnd_ready, 1);
    check("rst_alarm", alarm, 0);

    // Buffer 7, then swap
    rnd = 5'd7; rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    check("buf7_next_ready", next_ready, 1);
    check("buf7_rnd_ready", rnd_ready, 0);
    switch_req = 1'b1;
    tick();
    switch_req = 1'b0;
    check("swap7_p", p_det, 7);
    check("swap7_prev", p_det_prev, 1);
    check("swap7_ack", switch_ack, 1);
    check("swap7_next_ready", next_ready, 0);
    check("swap7_rnd_ready", rnd_ready, 1);
    tick();
    check("swap7_ack_pulse", switch_ack, 0);

    // Illegal candidates: 0, 31, current p_det, 0 -> four consecutive rejections
    rnd_valid = 1'b1;
    rnd = 5'd0;  tick(); check("rej0_next_ready", next_ready, 0);
    rnd = 5'd31; tick(); check("rej31_next_ready", next_ready, 0);
    rnd = 5'd7;  tick(); check("rej7_next_ready", next_ready, 0);
    check("rej3_alarm", alarm, 0);
    rnd = 5'd0;  tick(); check("rej0b_next_ready", next_ready, 0);
    check("rej4_alarm", alarm, HealthEn);
    rnd = 5'd12; tick(); check("acc12_next_ready", next_ready, 1);
    rnd_valid = 1'b0;
    check("acc12_alarm_sticky", alarm, HealthEn);
    switch_req = 1'b1;
    tick();
    switch_req = 1'b0;
    check("swap12_p", p_det, 12);
    check("swap12_prev", p_det_prev, 7);
    check("swap12_ack", switch_ack, 1);
    tick();

    // Stall: request with empty buffer for 10 cycles
    switch_req = 1'b1;
    ack_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (switch_ack) ack_seen++;
    end
    check("stall_no_ack", ack_seen, 0);
    check("stall_p", p_det, 12);
    rnd = 5'd3; rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    check("stall_k_next_ready", next_ready, 1);
    check("stall_k_p", p_det, 12);
    check("stall_k_ack", switch_ack, 0);
    tick();
    check("stall_k1_p", p_det, 3);
    check("stall_k1_prev", p_det_prev, 12);
    check("stall_k1_ack", switch_ack, 1);
    switch_req = 1'b0;
    tick();
    check("stall_ack_pulse", switch_ack, 0);

    // Asynchronous reset in the middle of a stall
    switch_req = 1'b1;
    tick();
    tick();
    check("pre_rst_p", p_det, 3);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_p", p_det, 1);
    check("async_rst_prev", p_det_prev, 1);
    check("async_rst_ack", switch_ack, 0);
    check("async_rst_next_ready", next_ready, 0);
    check("async_rst_alarm", alarm, 0);
    rst = 1'b0;
    switch_req = 1'b0;
    rnd = 5'd5; rnd_valid = 1'b1;
    tick();
    rnd_valid = 1'b0;
    check("post_rst_buf", next_ready, 1);
    tick();
    check("post_rst_no_ack", switch_ack, 0);
    check("post_rst_p", p_det, 1);

    // REFRESH_PERIOD = 3 (first request after reset refreshes)
    offer3(5'd9, "p3_buf9");
    req3(5'd9, 5'd1, "p3_swap9");
    offer3(5'd10, "p3_buf10");
    req3(5'd9, 5'd1, "p3_r1");
    req3(5'd9, 5'd1, "p3_r2");
    req3(5'd10, 5'd9, "p3_r3");
    offer3(5'd11, "p3_buf11");
    req3(5'd10, 5'd9, "p3_s_r1");
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    req3(5'd11, 5'd10, "p3_s_r2");
    offer3(5'd13, "p3_buf13");
    req3(5'd11, 5'd10, "p3_t_r1");
    // start together with the request: the request refreshes
    start3 = 1'b1;
    switch_req3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("p3_start_req_ack", switch_ack3, 1);
    check("p3_start_req_p", p_det3, 13);
    check("p3_start_req_prev", p_det_prev3, 11);
    tick();
    switch_req3 = 1'b0;
    check("p3_start_req_ack_low", switch_ack3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p_det_scheduler.md
Name: p_det_scheduler

Overview:
- Sequences the representation selector p_det that drives the parameter extractor, which supplies L, L_inv, P, MC and B to the CLM datapath.
- Prefetches a fresh random selector from the RNG and rejects illegal values.
- Swaps selectors at round boundaries on a req/ack handshake with the round controller, stalling when no candidate is buffered.
- Exposes the previous selector so the datapath can chain the old L_inv with the new L.

Parameters:
- REFRESH_PERIOD, 1, number of accepted switch requests per selector refresh (>=1).
- MAX_REJECT, 8, consecutive RNG rejections that trigger the alarm (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rnd  in  5  raw random candidate
- rnd_valid  in  1  rnd is valid
- rnd_ready  out  1  block accepts rnd this cycle
- start  in  1  one-cycle pulse at start of an encryption
- switch_req  in  1  round boundary reached; held high until switch_ack is seen
- switch_ack  out  1  one-cycle pulse; p_det/p_det_prev are updated in the same cycle
- p_det  out  5  current selector (1..30), drives the extractor
- p_det_prev  out  5  selector in force before the last refresh
- next_ready  out  1  a candidate is buffered
- alarm  out  1  RNG health alarm

Behaviour:
- Reset (asynchronous, immediate): p_det=1, p_det_prev=1, switch_ack=0, next_ready=0, alarm=0, period counter cnt=REFRESH_PERIOD-1, state=RUN, buffer empty. Any pending request is dropped, and the requester must re-assert switch_req.
- Prefetch buffer: holds nxt and nxt_valid; next_ready=nxt_valid; rnd_ready = !nxt_valid.
- Candidate handshake: on a clock edge with rnd_valid && rnd_ready, accept rnd only if 1<=rnd<=30 and rnd!=p_det. If accepted, nxt<=rnd and nxt_valid<=1; otherwise drop rnd silently.
- States: RUN and STALL.
- RUN, switch_req high, switch_ack low:
  - If cnt != REFRESH_PERIOD-1: cnt++, ack pulse next cycle, selectors unchanged.
  - Else if nxt_valid: p_det_prev<=p_det, p_det<=nxt, nxt_valid<=0, cnt<=0, ack pulse next cycle.
  - Else go to STALL; no ack.
- STALL: wait for nxt_valid, then perform the refresh swap on the next edge, pulse ack, and return to RUN.
- Latency: with a candidate buffered, the swap and ack are visible 1 cycle after switch_req is sampled. When STALL is exited, the candidate is accepted at edge k and the swap happens at edge k+1. There is no bypass from rnd to p_det.
- No double count: switch_req is ignored in the cycle switch_ack=1. The requester drops req after sampling ack.
- start: sets cnt<=REFRESH_PERIOD-1, so the next accepted switch request refreshes. start together with switch_req in the same cycle: start is applied first, so that request refreshes. start during STALL has no further effect.
- Rejection against p_det uses the pre-swap value when a swap and an accept coincide. A swap and an accept cannot coincide in practice, because rnd_ready=0 whenever nxt_valid=1.
- p_det is never 0 or 31, so the extractor's default branch is unreachable.

Optional Feature:
- RNG_HEALTH_EN defined:
  - A counter of consecutive rejected candidates is cleared by any accepted candidate.
  - When the counter reaches MAX_REJECT, alarm goes high and stays high until rst.
  - Scheduling continues normally after the alarm.
- RNG_HEALTH_EN not defined: alarm tied to 0, no counter.

Test Plan:
- Reset, then rnd=7 with rnd_valid → next_ready=1 one cycle later. switch_req → next cycle p_det=7, p_det_prev=1, switch_ack pulse of exactly 1 cycle, next_ready=0, rnd_ready=1.
- With p_det=7, offer rnd=0, 31, 7 → none accepted, next_ready stays 0. Then offer rnd=12 → accepted, nxt=12.
- Hold switch_req 10 cycles with rnd_valid=0 → no ack, p_det unchanged. Then rnd=3 valid at edge k → swap at edge k+1, p_det=3, ack pulse.
- REFRESH_PERIOD=3, candidate buffered → requests 1 and 2 are acked with p_det unchanged, request 3 swaps. Pulse start after request 1 → request 2 swaps.
- Assert rst asynchronously mid-STALL → outputs return to reset values before the next clk edge. The dropped request is not acked after rst is released.
- With RNG_HEALTH_EN and MAX_REJECT=4, offer rnd=0 four times → alarm=1 and stays 1 after subsequent valid candidates until rst.
